mips_multicycle_control: RTL and testbench
==========================================

Name: mips_multicycle_control

Overview:
Moore-style main controller for the multi-cycle MIPS datapath. It sequences fetch, decode, execute, memory and write-back steps per instruction, and drives every datapath enable and mux select. It supports lw, sw, R-type, beq, j and addi, and stalls memory states on a memory-ready handshake. It replaces the combinational single-cycle control unit when the shared-memory multi-cycle datapath is used.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  6  instruction[31:26] from IR; sampled in DECODE only
mem_ready  in  1  memory completes current access this cycle
PCWrite  out  1  unconditional PC load
PCWriteCond  out  1  PC load if ALU zero
IorD  out  1  memory address: 0=PC, 1=ALUOut
MemRead  out  1  memory read strobe
MemWrite  out  1  memory write strobe
IRWrite  out  1  instruction register load
MemtoReg  out  1  write-back data: 0=ALUOut, 1=MDR
RegDst  out  1  dest reg: 0=rt, 1=rd
RegWrite  out  1  register file write
ALUSrcA  out  1  0=PC, 1=A
ALUSrcB  out  2  00=B, 01=4, 10=sign-ext imm, 11=sign-ext imm<<2
ALUOp  out  2  00=add, 01=sub, 10=funct
PCSource  out  2  00=ALU result, 01=ALUOut, 10=jump target
state  out  4  current state encoding (debug)
instr_done  out  1  one-cycle pulse on last cycle of an instruction
illegal_op  out  1  one-cycle pulse in DECODE on unsupported opcode
instr_count  out  CNT_W  retired instructions, wraps modulo 2^CNT_W

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EXEC=10, ADDI_WB=11. Codes 12-15 are unreachable. If one is entered, the next state is FETCH, and all strobes are 0 in that cycle.
- Reset (async, rst_n=0): state=FETCH, instr_count=0. All outputs are forced 0 while rst_n=0, including FETCH strobes. Normal operation starts on the first rising edge after release.
- Transitions:
  - FETCH goes to DECODE when mem_ready=1, else stays in FETCH.
  - DECODE branches on opcode: 100011 or 101011 to MEM_ADDR, 000000 to R_EXEC, 000100 to BRANCH, 000010 to JUMP, 001000 to ADDI_EXEC. Any other opcode goes to FETCH with illegal_op=1.
  - MEM_ADDR goes to MEM_READ for lw and MEM_WRITE for sw. The opcode is latched in DECODE for this decision; the live opcode is not used.
  - MEM_READ goes to MEM_WB when mem_ready=1, else holds.
  - MEM_WRITE goes to FETCH when mem_ready=1, else holds.
  - MEM_WB, R_WB, BRANCH, JUMP and ADDI_WB go to FETCH.
  - R_EXEC goes to R_WB. ADDI_EXEC goes to ADDI_WB.
- Outputs are decoded from state. Unlisted outputs are 0.
  - FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite and PCWrite equal mem_ready, so PC and IR load exactly once per fetch.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00.
  - MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - MEM_READ: MemRead=1, IorD=1.
  - MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0.
  - MEM_WRITE: MemWrite=1, IorD=1. Held high for the whole stall.
  - R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
  - R_WB: RegWrite=1, RegDst=1, MemtoReg=0.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01.
  - JUMP: PCWrite=1, PCSource=10.
  - ADDI_EXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - ADDI_WB: RegWrite=1, RegDst=0, MemtoReg=0.
- Strobe guarantees: RegWrite and MemWrite are never high in the same cycle. MemRead and MemWrite are never both high.
- instr_done is 1 in the cycle whose next state is FETCH from a completing state:
  - MEM_WB, R_WB, BRANCH, JUMP, ADDI_WB;
  - MEM_WRITE with mem_ready=1.
  - instr_done is not raised on the illegal_op path.
- instr_count increments on each clock edge where instr_done=1. It wraps from all-ones to 0.
- Minimum cycles with mem_ready tied 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Reset asserted mid-instruction immediately forces outputs to 0 and state to FETCH. No partial write strobe survives reset.

Test Plan:
- Hold rst_n=0 for 3 cycles with mem_ready=1, then release -> all outputs 0 during reset; state=0 and PCWrite=IRWrite=MemRead=1 in the first cycle after release.
- mem_ready=1, opcode=100011 -> state sequence 0,1,2,3,4,0; RegWrite=MemtoReg=1 only in state 4; instr_done pulses once; instr_count 0→1.
- opcode=101011, mem_ready=0 for 3 cycles in MEM_WRITE -> MemWrite=1 and IorD=1 for 4 cycles, no RegWrite; instr_done only on the mem_ready=1 cycle.
- Back-to-back R-type (000000), beq (000100), j (000010), addi (001000) -> per-state outputs match the table; ALUOp=10 in R_EXEC and 01 in BRANCH; PCSource=10 in JUMP; instr_count=4.
- opcode=111111 in DECODE -> illegal_op=1 for one cycle, return to FETCH, instr_count unchanged, no write strobes.
- With CNT_W=4, preload count via 15 retired instructions, retire one more -> instr_count wraps 15→0. Separately, assert rst_n=0 during MEM_READ stall -> outputs 0 asynchronously and state=0.

Source files
------------

// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control
//   Moore-style main controller for the shared-memory multi-cycle MIPS
//   datapath. Sequences fetch/decode/execute/memory/write-back for
//   lw, sw, R-type, beq, j and addi. Memory states stall on mem_ready.
//
// Ports
//   clk, rst_n         clock (rising edge), async active-low reset
//   opcode[5:0]        IR[31:26], looked at in DECODE only
//   mem_ready          memory finishes the current access this cycle
//   PCWrite .. PCSource datapath enables and mux selects
//   state[3:0]         current state code (debug)
//   instr_done         pulse on the last cycle of a retiring instruction
//   illegal_op         pulse in DECODE on an unsupported opcode
//   instr_count        retired-instruction counter, wraps
module mips_multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic [3:0]       state,
  output logic             instr_done,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  state_t           cur, nxt;
  logic             is_sw;     // lw/sw choice captured in DECODE
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur   <= S_FETCH;
      is_sw <= 1'b0;
      cnt   <= '0;
    end else begin
      cur <= nxt;
      if (cur == S_DECODE) is_sw <= (opcode == OP_SW);
      if (instr_done)      cnt   <= cnt + 1'b1;
    end
  end

  // Every output is gated by rst_n so nothing (including FETCH strobes)
  // escapes while reset is held, and a mid-instruction reset kills any
  // write strobe immediately rather than at the next edge.
  always_comb begin
    nxt         = S_FETCH;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    if (rst_n) begin
      case (cur)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          // PC and IR load only on the completing cycle of the fetch.
          IRWrite = mem_ready;
          PCWrite = mem_ready;
          nxt     = mem_ready ? S_DECODE : S_FETCH;
        end
        S_DECODE: begin
          ALUSrcB = 2'b11;
          case (opcode)
            OP_LW, OP_SW: nxt = S_MEM_ADDR;
            OP_R:         nxt = S_R_EXEC;
            OP_BEQ:       nxt = S_BRANCH;
            OP_J:         nxt = S_JUMP;
            OP_ADDI:      nxt = S_ADDI_EXEC;
            default: begin
              nxt        = S_FETCH;
              illegal_op = 1'b1;
            end
          endcase
        end
        S_MEM_ADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          nxt     = is_sw ? S_MEM_WRITE : S_MEM_READ;
        end
        S_MEM_READ: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
          nxt     = mem_ready ? S_MEM_WB : S_MEM_READ;
        end
        S_MEM_WB: begin
          RegWrite   = 1'b1;
          MemtoReg   = 1'b1;
          instr_done = 1'b1;
        end
        S_MEM_WRITE: begin
          MemWrite   = 1'b1;
          IorD       = 1'b1;
          instr_done = mem_ready;
          nxt        = mem_ready ? S_FETCH : S_MEM_WRITE;
        end
        S_R_EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
          nxt     = S_R_WB;
        end
        S_R_WB: begin
          RegWrite   = 1'b1;
          RegDst     = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 2'b01;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
          instr_done  = 1'b1;
        end
        S_JUMP: begin
          PCWrite    = 1'b1;
          PCSource   = 2'b10;
          instr_done = 1'b1;
        end
        S_ADDI_EXEC: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          nxt     = S_ADDI_WB;
        end
        S_ADDI_WB: begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        // Codes 12-15: recover to FETCH with every strobe low.
        default: nxt = S_FETCH;
      endcase
    end
  end

  assign state       = rst_n ? cur : S_FETCH;
  assign instr_count = rst_n ? cnt : '0;

endmodule

// File: tb/tb_mips_multicycle_control.sv
module tb_mips_multicycle_control;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [5:0]    opcode = 6'd0;
  logic          mem_ready = 1'b1;
  logic          PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic          MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0]    ALUSrcB, ALUOp, PCSource;
  logic [3:0]    state;
  logic          instr_done, illegal_op;
  logic [CW-1:0] instr_count;

  mips_multicycle_control #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .state(state), .instr_done(instr_done),
    .illegal_op(illegal_op), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, asa;
    logic [1:0] asb, aop, psrc;
    logic [3:0] st;
    logic       done, ill;
    logic [CW-1:0] cnt;
  } ctl_t;

  ctl_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    failures = 0;
  logic [CW-1:0] cnt_model = '0;

  // Output table for one cycle, straight from the state/output listing.
  function automatic ctl_t expect_of(input bit rst, input logic [3:0] st,
                                     input logic mr, input logic [5:0] op,
                                     input logic [CW-1:0] cnt);
    ctl_t e;
    e = '0;
    if (rst) return e;
    e.st  = st;
    e.cnt = cnt;
    case (st)
      4'd0:  begin e.mr = 1; e.asb = 2'b01; e.irw = mr; e.pcw = mr; end
      4'd1:  begin
        e.asb = 2'b11;
        e.ill = !(op inside {6'b100011, 6'b101011, 6'b000000,
                             6'b000100, 6'b000010, 6'b001000});
      end
      4'd2:  begin e.asa = 1; e.asb = 2'b10; end
      4'd3:  begin e.mr = 1; e.iord = 1; end
      4'd4:  begin e.rw = 1; e.m2r = 1; e.done = 1; end
      4'd5:  begin e.mw = 1; e.iord = 1; e.done = mr; end
      4'd6:  begin e.asa = 1; e.aop = 2'b10; end
      4'd7:  begin e.rw = 1; e.rdst = 1; e.done = 1; end
      4'd8:  begin e.asa = 1; e.aop = 2'b01; e.pcwc = 1; e.psrc = 2'b01; e.done = 1; end
      4'd9:  begin e.pcw = 1; e.psrc = 2'b10; e.done = 1; end
      4'd10: begin e.asa = 1; e.asb = 2'b10; end
      4'd11: begin e.rw = 1; e.done = 1; end
      default: ;
    endcase
    return e;
  endfunction

  // Issue one cycle of stimulus (called at posedge+1) and queue its expectation.
  task automatic step(input bit rst, input logic [5:0] op, input logic mr,
                      input logic [3:0] st, input string nm);
    ctl_t e;
    rst_n     = !rst;
    opcode    = op;
    mem_ready = mr;
    if (rst) cnt_model = '0;
    e = expect_of(rst, st, mr, op, cnt_model);
    exp_q.push_back(e);
    name_q.push_back(nm);
    if (e.done) cnt_model = cnt_model + 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every falling edge with an outstanding expectation is compared.
  always @(negedge clk) begin
    ctl_t  a, e;
    string nm;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = '{PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
             MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
             state, instr_done, illegal_op, instr_count};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL %s: got %h expected %h (state got %0d exp %0d, cnt got %0d exp %0d)",
                 nm, a, e, a.st, e.st, a.cnt, e.cnt);
      end
    end
  end

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, J = 6'b000010, ADDI = 6'b001000;

  initial begin
    int guard;
    @(posedge clk);
    #1;
    // reset held with mem_ready=1: everything zero
    for (int i = 0; i < 3; i++) step(1, LW, 1, 4'd0, "reset_hold");
    // lw, no stalls
    step(0, LW, 1, 4'd0, "lw_fetch");
    step(0, LW, 1, 4'd1, "lw_decode");
    step(0, LW, 1, 4'd2, "lw_addr");
    step(0, LW, 1, 4'd3, "lw_read");
    step(0, LW, 1, 4'd4, "lw_wb");
    // sw; live opcode changed after DECODE must not matter; 3 stall cycles
    step(0, SW, 1, 4'd0, "sw_fetch");
    step(0, SW, 1, 4'd1, "sw_decode");
    step(0, RT, 1, 4'd2, "sw_addr_latched");
    step(0, RT, 0, 4'd5, "sw_stall0");
    step(0, RT, 0, 4'd5, "sw_stall1");
    step(0, RT, 0, 4'd5, "sw_stall2");
    step(0, RT, 1, 4'd5, "sw_done");
    // back-to-back R, beq, j, addi
    step(0, RT, 1, 4'd0, "r_fetch");
    step(0, RT, 1, 4'd1, "r_decode");
    step(0, RT, 1, 4'd6, "r_exec");
    step(0, RT, 1, 4'd7, "r_wb");
    step(0, BEQ, 1, 4'd0, "beq_fetch");
    step(0, BEQ, 1, 4'd1, "beq_decode");
    step(0, BEQ, 1, 4'd8, "beq_branch");
    step(0, J, 1, 4'd0, "j_fetch");
    step(0, J, 1, 4'd1, "j_decode");
    step(0, J, 1, 4'd9, "j_jump");
    step(0, ADDI, 1, 4'd0, "addi_fetch");
    step(0, ADDI, 1, 4'd1, "addi_decode");
    step(0, ADDI, 1, 4'd10, "addi_exec");
    step(0, ADDI, 1, 4'd11, "addi_wb");
    // illegal opcode: pulse, back to FETCH, no retire
    step(0, 6'b111111, 1, 4'd0, "ill_fetch");
    step(0, 6'b111111, 1, 4'd1, "ill_decode");
    // fetch stall: no IR/PC load until mem_ready
    step(0, J, 0, 4'd0, "fetch_stall");
    step(0, J, 1, 4'd0, "fetch_go");
    step(0, J, 1, 4'd1, "fill_decode");
    step(0, J, 1, 4'd9, "fill_jump");
    // count is 7 here; 9 more jumps reach 16 -> wraps to 0
    for (int k = 0; k < 9; k++) begin
      step(0, J, 1, 4'd0, "wrap_fetch");
      step(0, J, 1, 4'd1, "wrap_decode");
      step(0, J, 1, 4'd9, "wrap_jump");
    end
    step(0, LW, 1, 4'd0, "wrapped_fetch");
    // lw stalling in MEM_READ, then reset mid-cycle
    step(0, LW, 1, 4'd1, "lw2_decode");
    step(0, LW, 1, 4'd2, "lw2_addr");
    step(0, LW, 0, 4'd3, "lw2_stall");
    step(0, LW, 0, 4'd3, "lw2_stall");
    step(1, LW, 0, 4'd0, "reset_mid_read");
    step(0, LW, 1, 4'd0, "post_reset_fetch");
    step(0, LW, 1, 4'd1, "post_reset_decode");
    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
